// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: stage indices, stage-vector type and mult/div FSM states.
// Imported by the hazard unit and its mult/div stall sub-module.
package hazard_unit_pkg;

    localparam int unsigned NUM_STAGES = 5;

    localparam logic [2:0] IF_S  = 3'd0;
    localparam logic [2:0] ID_S  = 3'd1;
    localparam logic [2:0] EX_S  = 3'd2;
    localparam logic [2:0] MEM_S = 3'd3;
    localparam logic [2:0] WB_S  = 3'd4;

    // Wide enough for the largest legal MD_LATENCY (15).
    localparam int unsigned MD_CNT_W = 4;

    typedef logic [NUM_STAGES-1:0] stage_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic stage_vec_t stage_bit(input logic [2:0] s);
        stage_vec_t v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hazard_unit_md_stall_fsm.sv
// Mult/div occupancy tracker: holds EX for MD_LATENCY cycles from the md_start cycle,
// then presents md_done until MEM stops waiting. mem_exc aborts from any state.
module md_stall_fsm
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    input  logic mem_wait,
    input  logic mem_exc,
    output logic md_stall,
    output logic md_done
);

    // The start cycle itself is the first stall cycle, so BUSY covers the remaining ones.
    localparam logic [MD_CNT_W-1:0] CntLoad = MD_CNT_W'(MD_LATENCY - 1);
    localparam logic [MD_CNT_W-1:0] CntLast = MD_CNT_W'(1);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = BUSY;
                    cnt_d   = CntLoad;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CntLast;
                if (cnt_q == CntLast) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mem_wait) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (mem_exc) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        md_stall = ((state_q == IDLE) && md_start) || (state_q == BUSY);
        md_done  = (state_q == DONE) && !rst;
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: prioritised per-stage stall/flush requests (zero latency)
// plus saturating performance counters for stall and flush cycles.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             md_start,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             mem_exc,
    input  logic             perf_clr,
    output stage_vec_t       stall,
    output stage_vec_t       flush,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic load_use;
    logic mem_wait;
    logic md_stall;
    logic branch_flush;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign mem_wait = mem_req && !mem_ready;

    md_stall_fsm #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_stall_fsm (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .mem_wait (mem_wait),
        .mem_exc  (mem_exc),
        .md_stall (md_stall),
        .md_done  (md_done)
    );

    // A taken branch waits until neither MEM nor EX is held, so it is deferred, not dropped.
    assign branch_flush = ex_branch_taken && !mem_wait && !md_stall;

    always_comb begin
        stall = '0;
        flush = '0;
        if (rst) begin
            stall = '0;
            flush = '0;
        end else if (mem_exc) begin
            flush = stage_bit(MEM_S);
        end else begin
            if (branch_flush) begin
                flush = stage_bit(ID_S);
            end
            if (mem_wait) begin
                stall = stage_bit(MEM_S);
            end else if (md_stall) begin
                stall = stage_bit(EX_S);
            end else if (!branch_flush && load_use) begin
                stall = stage_bit(ID_S);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (perf_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((stall != '0) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((flush != '0) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scenarios followed by randomized traffic, all checked cycle by cycle against
// a behavioural model of the hazard rules (remaining-cycle count for mult/div).
module tb_hazard_unit;

    localparam int unsigned MD_LAT = 4;
    localparam int unsigned CW     = 4;
    localparam int          SAT    = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
    logic          md_start, mem_req, mem_ready, mem_exc, perf_clr;
    logic [4:0]    stall, flush;
    logic          md_done;
    logic [CW-1:0] stall_cycles, flush_events;

    int passed = 0;
    int total  = 0;

    // Model state: stall cycles still owed by an op in flight, result-ready flag, counters.
    int m_left = 0;
    bit m_done = 0;
    int m_sc   = 0;
    int m_fe   = 0;

    hazard_unit #(
        .MD_LATENCY (MD_LAT),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .md_start        (md_start),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .mem_exc         (mem_exc),
        .perf_clr        (perf_clr),
        .stall           (stall),
        .flush           (flush),
        .md_done         (md_done),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Called just after a rising edge with inputs set; checks outputs then advances one cycle.
    task automatic cycle(input string tag);
        bit         lu, mw, mds, brf;
        logic [4:0] es, ef;
        logic       ed;
        #1;
        if (rst) begin
            m_left = 0;
            m_done = 0;
            m_sc   = 0;
            m_fe   = 0;
        end
        lu  = ex_mem_read && (ex_rd != 0) &&
              ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        mw  = mem_req && !mem_ready;
        mds = (m_left > 0) || (!m_done && md_start);
        brf = ex_branch_taken && !mw && !mds;
        es  = 5'b00000;
        ef  = 5'b00000;
        ed  = m_done && !rst;
        if (!rst) begin
            if (mem_exc)  ef = 5'b01000;
            else if (brf) ef = 5'b00010;
            if (mem_exc)        es = 5'b00000;
            else if (mw)        es = 5'b01000;
            else if (mds)       es = 5'b00100;
            else if (brf)       es = 5'b00000;
            else if (lu)        es = 5'b00010;
        end
        check({tag, ".stall"}, 16'(stall), 16'(es));
        check({tag, ".flush"}, 16'(flush), 16'(ef));
        check({tag, ".md_done"}, 16'(md_done), 16'(ed));
        check({tag, ".stall_cycles"}, 16'(stall_cycles), 16'(m_sc));
        check({tag, ".flush_events"}, 16'(flush_events), 16'(m_fe));
        @(posedge clk);
        if (!rst) begin
            if (perf_clr) begin
                m_sc = 0;
                m_fe = 0;
            end else begin
                if (es != 0 && m_sc < SAT) m_sc++;
                if (ef != 0 && m_fe < SAT) m_fe++;
            end
            if (mem_exc) begin
                m_left = 0;
                m_done = 0;
            end else if (m_done) begin
                if (!mw) m_done = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end else if (md_start) begin
                m_left = MD_LAT - 1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0; ex_branch_taken = 0;
        md_start = 0; mem_req = 0; mem_ready = 0; mem_exc = 0; perf_clr = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b0;
        cycle("post_reset");

        // Load-use on rs, then the same pattern targeting r0.
        ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
        cycle("load_use");
        check("load_use_cnt", 16'(stall_cycles), 16'd1);
        ex_rd = 0; id_rs = 0;
        cycle("load_use_r0");
        idle_inputs();
        ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1;
        cycle("load_use_rt");
        idle_inputs();

        // Mult/div with md_start held through the op and the done cycle.
        md_start = 1;
        for (int i = 0; i < MD_LAT; i++) cycle("md_busy");
        cycle("md_done");
        md_start = 0;
        cycle("md_idle");

        // Memory wait masking a load-use stall.
        mem_req = 1; mem_ready = 0; ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
        for (int i = 0; i < 3; i++) cycle("mem_wait");
        mem_ready = 1;
        cycle("mem_wait_release");
        idle_inputs();

        // Taken branch deferred behind a memory wait.
        mem_req = 1; ex_branch_taken = 1;
        cycle("br_defer0");
        cycle("br_defer1");
        mem_ready = 1;
        cycle("br_fire");
        idle_inputs();

        // Exception while BUSY aborts the op.
        md_start = 1;
        cycle("exc_start");
        md_start = 0;
        cycle("exc_busy");
        mem_exc = 1;
        cycle("exc_hit");
        mem_exc = 0;
        cycle("exc_after0");
        cycle("exc_after1");

        // Counter saturation and clear-over-increment.
        ex_mem_read = 1; ex_rd = 9; id_rs = 9; id_uses_rs = 1;
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat_value", 16'(stall_cycles), 16'(SAT));
        perf_clr = 1;
        cycle("clr_with_stall");
        perf_clr = 0;
        check("clr_value", 16'(stall_cycles), 16'd0);
        idle_inputs();
        cycle("clr_idle");

        // Asynchronous reset in the middle of an op.
        md_start = 1;
        cycle("rst_mid_start");
        md_start = 0;
        cycle("rst_mid_busy");
        rst = 1;
        cycle("rst_mid_hold");
        rst = 0;
        for (int i = 0; i < MD_LAT + 1; i++) cycle("rst_mid_after");

        // Randomized traffic over a small register space so hazards actually collide.
        for (int n = 0; n < 800; n++) begin
            rst             = ($urandom_range(0, 149) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            md_start        = ($urandom_range(0, 4) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = 1'($urandom_range(0, 1));
            mem_exc         = ($urandom_range(0, 24) == 0);
            perf_clr        = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
